// File: rtl/depacketizer.sv
// rtl/depacketizer.sv - Ethernet/IPv4/UDP receive parser that unpacks IQ samples into the sample FIFO
module depacketizer #(
    parameter logic [47:0] LOCAL_MAC   = 48'h021234567890,
    parameter logic [31:0] LOCAL_IP    = {8'd192, 8'd168, 8'd50, 8'd50},
    parameter logic [15:0] LOCAL_PORT  = 16'd32179,
    parameter logic [15:0] MAX_UDP_LEN = 16'd1480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_dval,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic        seq_gap,
    output logic [63:0] last_seq,
    output logic [15:0] drop_count,
    output logic [15:0] ovf_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SEQ,
        S_PAYLOAD,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic        mac_uc_q, mac_uc_d;
    logic        mac_bc_q, mac_bc_d;
    logic [7:0]  udp_hi_q, udp_hi_d;
    logic [8:0]  words_tot_q, words_tot_d;
    logic [8:0]  words_done_q, words_done_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] acc_q, acc_d;
    logic [63:0] seq_rx_q, seq_rx_d;
    logic        have_prev_q, have_prev_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_drop_q, frame_drop_d;
    logic        seq_gap_q, seq_gap_d;
    logic [63:0] last_seq_q, last_seq_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] ovf_count_q, ovf_count_d;

    state_t      st;
    logic [10:0] ix;
    logic        bad;
    logic        uc;
    logic        bc;
    logic        drop;
    logic [15:0] len;

    function automatic logic [7:0] mac_byte(input logic [2:0] i);
        case (i)
            3'd0:    mac_byte = LOCAL_MAC[47:40];
            3'd1:    mac_byte = LOCAL_MAC[39:32];
            3'd2:    mac_byte = LOCAL_MAC[31:24];
            3'd3:    mac_byte = LOCAL_MAC[23:16];
            3'd4:    mac_byte = LOCAL_MAC[15:8];
            default: mac_byte = LOCAL_MAC[7:0];
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mac_uc_d     = mac_uc_q;
        mac_bc_d     = mac_bc_q;
        udp_hi_d     = udp_hi_q;
        words_tot_d  = words_tot_q;
        words_done_d = words_done_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        seq_rx_d     = seq_rx_q;
        have_prev_d  = have_prev_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        frame_ok_d   = 1'b0;
        frame_drop_d = 1'b0;
        seq_gap_d    = 1'b0;
        last_seq_d   = last_seq_q;
        drop_count_d = drop_count_q;
        ovf_count_d  = ovf_count_q;
        st           = state_q;
        ix           = idx_q;
        bad          = 1'b0;
        uc           = 1'b0;
        bc           = 1'b0;
        drop         = 1'b0;
        len          = 16'd0;

        if (rx_dval) begin
            // An SOP always restarts parsing; in a non-idle state it also aborts the old frame.
            if (rx_sop) begin
                st   = S_HEADER;
                ix   = 11'd0;
                drop = (state_q != S_IDLE);
            end
            if (st != S_IDLE) begin
                state_d = st;
                idx_d   = ix + 11'd1;
                case (st)
                    S_HEADER: begin
                        if (ix < 11'd6) begin
                            uc       = (ix == 11'd0 || mac_uc_q) && (rx_data == mac_byte(ix[2:0]));
                            bc       = (ix == 11'd0 || mac_bc_q) && (rx_data == 8'hFF);
                            mac_uc_d = uc;
                            mac_bc_d = bc;
                            bad      = !(uc || bc);
                        end
                        case (ix)
                            11'd12: bad = (rx_data != 8'h08);
                            11'd13: bad = (rx_data != 8'h00);
                            11'd14: bad = (rx_data != 8'h45);
                            11'd23: bad = (rx_data != 8'h11);
                            11'd30: bad = (rx_data != LOCAL_IP[31:24]);
                            11'd31: bad = (rx_data != LOCAL_IP[23:16]);
                            11'd32: bad = (rx_data != LOCAL_IP[15:8]);
                            11'd33: bad = (rx_data != LOCAL_IP[7:0]);
                            11'd36: bad = (rx_data != LOCAL_PORT[15:8]);
                            11'd37: bad = (rx_data != LOCAL_PORT[7:0]);
                            11'd38: udp_hi_d = rx_data;
                            11'd39: begin
                                len         = {udp_hi_q, rx_data};
                                bad         = (len < 16'd16) || (len > MAX_UDP_LEN) || (len[1:0] != 2'b00);
                                words_tot_d = 9'((len - 16'd16) >> 2);
                            end
                            default: ;
                        endcase
                        if (bad) begin
                            state_d = S_DISCARD;
                        end else if (ix == 11'd41) begin
                            state_d = S_SEQ;
                        end
                    end
                    S_SEQ: begin
                        seq_rx_d = {rx_data, seq_rx_q[63:8]};
                        if (ix == 11'd49) begin
                            state_d      = S_PAYLOAD;
                            words_done_d = 9'd0;
                            lane_d       = 2'd0;
                        end
                    end
                    S_PAYLOAD: begin
                        if (words_done_q < words_tot_q) begin
                            lane_d = lane_q + 2'd1;
                            case (lane_q)
                                2'd0: acc_d[7:0]   = rx_data;
                                2'd1: acc_d[15:8]  = rx_data;
                                2'd2: acc_d[23:16] = rx_data;
                                default: begin
                                    words_done_d = words_done_q + 9'd1;
                                    if (wr_full) begin
                                        if (ovf_count_q != 16'hFFFF) begin
                                            ovf_count_d = ovf_count_q + 16'd1;
                                        end
                                    end else begin
                                        wr_en_d   = 1'b1;
                                        wr_data_d = {acc_q[15:8], acc_q[7:0], rx_data, acc_q[23:16]};
                                    end
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
                if (rx_eop) begin
                    // Judged on the post-byte state so a zero-word frame ending on the last SEQ byte is accepted.
                    if (state_d == S_PAYLOAD && words_done_d == words_tot_d && !rx_err) begin
                        frame_ok_d  = 1'b1;
                        last_seq_d  = seq_rx_d;
                        have_prev_d = 1'b1;
                        seq_gap_d   = have_prev_q && (seq_rx_d != last_seq_q + 64'd1);
                    end else begin
                        drop = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            if (drop) begin
                frame_drop_d = 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 11'd0;
            mac_uc_q     <= 1'b0;
            mac_bc_q     <= 1'b0;
            udp_hi_q     <= 8'd0;
            words_tot_q  <= 9'd0;
            words_done_q <= 9'd0;
            lane_q       <= 2'd0;
            acc_q        <= 24'd0;
            seq_rx_q     <= 64'd0;
            have_prev_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 32'd0;
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            seq_gap_q    <= 1'b0;
            last_seq_q   <= 64'd0;
            drop_count_q <= 16'd0;
            ovf_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mac_uc_q     <= mac_uc_d;
            mac_bc_q     <= mac_bc_d;
            udp_hi_q     <= udp_hi_d;
            words_tot_q  <= words_tot_d;
            words_done_q <= words_done_d;
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            seq_rx_q     <= seq_rx_d;
            have_prev_q  <= have_prev_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_ok_q   <= frame_ok_d;
            frame_drop_q <= frame_drop_d;
            seq_gap_q    <= seq_gap_d;
            last_seq_q   <= last_seq_d;
            drop_count_q <= drop_count_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign frame_ok   = frame_ok_q;
    assign frame_drop = frame_drop_q;
    assign seq_gap    = seq_gap_q;
    assign last_seq   = last_seq_q;
    assign drop_count = drop_count_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_depacketizer.sv
// tb/tb_depacketizer.sv - randomized bench for depacketizer against a frame-level reference model
module tb_depacketizer;

    localparam logic [47:0] LMAC  = 48'h021234567890;
    localparam logic [31:0] LIP   = {8'd192, 8'd168, 8'd50, 8'd50};
    localparam logic [15:0] LPORT = 16'd32179;

    typedef struct {
        bit          ok;
        bit          gap;
        logic [63:0] seq;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_dval, rx_sop, rx_eop, rx_err;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        frame_ok, frame_drop, seq_gap;
    logic [63:0] last_seq;
    logic [15:0] drop_count, ovf_count;

    depacketizer dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dval(rx_dval), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_err(rx_err), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .frame_ok(frame_ok), .frame_drop(frame_drop), .seq_gap(seq_gap), .last_seq(last_seq),
        .drop_count(drop_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    logic [7:0]  fb[$];
    bit          full_w[512];
    bit          frame_err;
    int          gap_pct = 10;
    logic [31:0] exp_wr[$];
    ev_t         exp_ev[$];
    int          n_total = 0, n_bad = 0;
    int          obs_wr = 0, obs_ok = 0, obs_drop = 0, obs_gap = 0;
    int          m_drop = 0, m_ovf = 0;
    bit          m_have = 0;
    logic [63:0] m_last = 64'd0;
    int          s_wr, s_ok, s_drop, s_gap;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] port, input logic [15:0] ulen,
                         input logic [63:0] seq, input bit ramp, input int extra);
        int np;
        logic [15:0] k, t;
        fb.delete();
        for (int i = 0; i < 512; i++) full_w[i] = 1'b0;
        for (int i = 0; i < 6; i++) fb.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
        fb.push_back(8'h08); fb.push_back(8'h00); fb.push_back(8'h45); fb.push_back(8'($urandom));
        t = ulen + 16'd20;
        fb.push_back(t[15:8]); fb.push_back(t[7:0]);
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        fb.push_back(8'h11);
        for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) fb.push_back(LIP[31-8*i -: 8]);
        fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
        fb.push_back(port[15:8]); fb.push_back(port[7:0]);
        fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
        fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
        for (int i = 0; i < 8; i++) fb.push_back(seq[8*i +: 8]);
        np = (ulen >= 16) ? int'(ulen) - 16 : 0;
        if (np > 1464) np = 1464;
        for (int b = 0; b < np; b++) begin
            k = 16'(b / 4);
            if (!ramp) fb.push_back(8'($urandom));
            else case (b % 4)
                0: fb.push_back(k[7:0]);
                1: fb.push_back(k[15:8]);
                2: fb.push_back(~k[7:0]);
                default: fb.push_back(~k[15:8]);
            endcase
        end
        for (int i = 0; i < extra; i++) fb.push_back(8'($urandom));
    endtask

    // Frame-level reference: term 0 = ends with EOP, 1 = aborted by next SOP, 2 = cut by reset.
    task automatic model_frame(input int term);
        int n, total, avail, w;
        bit hok, acc;
        logic [15:0] len;
        logic [47:0] dmac;
        logic [63:0] seq;
        ev_t ev;
        n = fb.size(); hok = (n >= 42); len = 0; seq = 0; total = 0; avail = 0;
        if (hok) begin
            dmac = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
            len  = {fb[38], fb[39]};
            hok  = (dmac == LMAC || dmac == 48'hFFFF_FFFF_FFFF) && fb[12] == 8'h08 && fb[13] == 8'h00
                && fb[14] == 8'h45 && fb[23] == 8'h11 && {fb[30], fb[31], fb[32], fb[33]} == LIP
                && {fb[36], fb[37]} == LPORT && len >= 16 && len <= 1480 && (len % 4) == 0;
        end
        if (hok) begin
            total = (int'(len) - 16) / 4;
            avail = (n >= 50) ? (n - 50) / 4 : 0;
            w = (avail < total) ? avail : total;
            for (int k = 0; k < w; k++) begin
                if (full_w[k]) begin
                    if (m_ovf < 65535) m_ovf++;
                end else begin
                    exp_wr.push_back({fb[51+4*k], fb[50+4*k], fb[53+4*k], fb[52+4*k]});
                end
            end
        end
        if (n >= 50) for (int i = 0; i < 8; i++) seq[8*i +: 8] = fb[42+i];
        if (term == 2) return;
        acc = (term == 0) && !frame_err && hok && n >= 50 && avail >= total;
        ev.ok = acc;
        ev.gap = acc && m_have && (seq != m_last + 64'd1);
        ev.seq = seq;
        exp_ev.push_back(ev);
        if (acc) begin
            m_last = seq;
            m_have = 1'b1;
        end else if (m_drop < 65535) begin
            m_drop++;
        end
    endtask

    task automatic send(input int term, input bit b2b);
        int p;
        for (int i = 0; i < fb.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                rx_dval = 1'b0; rx_data = 8'($urandom); rx_sop = 1'($urandom);
                rx_eop = 1'($urandom); rx_err = 1'($urandom); wr_full = 1'($urandom);
            end
            @(negedge clk);
            rx_dval = 1'b1;
            rx_data = fb[i];
            rx_sop  = (i == 0);
            rx_eop  = (term == 0) && (i == fb.size() - 1);
            rx_err  = rx_eop ? frame_err : 1'($urandom);
            p = i - 50;
            if (i >= 50 && p % 4 == 3 && p / 4 < 512) wr_full = full_w[p/4];
            else wr_full = 1'($urandom);
        end
        if (!b2b) begin
            @(negedge clk);
            rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; wr_full = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (3) @(negedge clk);
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("ovf_count", 64'(ovf_count), 64'(m_ovf));
        check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        check("events_outstanding", 64'(exp_ev.size()), 64'd0);
    endtask

    task automatic run(input int term, input bit b2b);
        model_frame(term);
        send(term, b2b);
        if (!b2b) end_frame();
    endtask

    task automatic snap();
        s_wr = obs_wr; s_ok = obs_ok; s_drop = obs_drop; s_gap = obs_gap;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_frame_ok"}, 64'(frame_ok), 64'd0);
        check({tag, "_frame_drop"}, 64'(frame_drop), 64'd0);
        check({tag, "_seq_gap"}, 64'(seq_gap), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_last_seq"}, last_seq, 64'd0);
        check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
        check({tag, "_ovf_count"}, 64'(ovf_count), 64'd0);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rx_dval = 1'b0;
        #2 rst = 1'b1;
        #1 if (chk) check_zero_outputs("rst_mid");
        exp_wr.delete(); exp_ev.delete();
        m_drop = 0; m_ovf = 0; m_have = 1'b0; m_last = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                obs_wr++;
                check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) check("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
            end
            if (frame_ok || frame_drop) begin
                ev_t ev;
                obs_ok += int'(frame_ok);
                obs_drop += int'(frame_drop);
                obs_gap += int'(seq_gap);
                check("event_expected", 64'(exp_ev.size() != 0), 64'd1);
                if (exp_ev.size() != 0) begin
                    ev = exp_ev.pop_front();
                    check("frame_ok", 64'(frame_ok), 64'(ev.ok));
                    check("frame_drop", 64'(frame_drop), 64'(!ev.ok));
                    check("seq_gap", 64'(seq_gap), 64'(ev.gap));
                    if (ev.ok) check("last_seq", last_seq, ev.seq);
                end
            end else if (seq_gap) begin
                check("seq_gap_without_ok", 64'(seq_gap), 64'd0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int cnt, idx, term;
        bit b2b;
        logic [15:0] ulen;
        logic [63:0] sq;
        int hdr_idx[11] = '{0, 3, 5, 12, 13, 14, 23, 30, 33, 36, 37};
        rst = 1'b1; rx_data = 8'd0; rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rx_err = 1'b0; wr_full = 1'b0; frame_err = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("por");
        rst = 1'b0;

        // Nominal packetizer frame
        snap();
        build(LMAC, LPORT, 16'h05C8, 64'd0, 1'b1, 0);
        run(0, 1'b0);
        check("nominal_writes", 64'(obs_wr - s_wr), 64'd366);
        check("nominal_ok", 64'(obs_ok - s_ok), 64'd1);
        check("nominal_last_seq", last_seq, 64'd0);
        check("nominal_gap", 64'(obs_gap - s_gap), 64'd0);

        // Sequence gap and 64-bit wrap
        do_reset(1'b0);
        snap();
        build(LMAC, LPORT, 16'd32, 64'd5, 1'b0, 0); run(0, 1'b0);
        build(LMAC, LPORT, 16'd32, 64'd6, 1'b0, 0); run(0, 1'b0);
        build(LMAC, LPORT, 16'd32, 64'd8, 1'b0, 0); run(0, 1'b0);
        check("gap_568_count", 64'(obs_gap - s_gap), 64'd1);
        check("gap_568_last_seq", last_seq, 64'd8);
        build(LMAC, LPORT, 16'd20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0); run(0, 1'b0);
        snap();
        build(LMAC, LPORT, 16'd20, 64'd0, 1'b0, 0); run(0, 1'b0);
        check("wrap_gap", 64'(obs_gap - s_gap), 64'd0);
        check("wrap_ok", 64'(obs_ok - s_ok), 64'd1);

        // Address filter
        do_reset(1'b0);
        snap();
        build(48'h021234567891, LPORT, 16'd48, 64'd1, 1'b0, 0); run(0, 1'b0);
        check("wrong_mac_drop_count", 64'(drop_count), 64'd1);
        check("wrong_mac_writes", 64'(obs_wr - s_wr), 64'd0);
        snap();
        build(48'hFFFF_FFFF_FFFF, LPORT, 16'd48, 64'd2, 1'b0, 0); run(0, 1'b0);
        check("bcast_ok", 64'(obs_ok - s_ok), 64'd1);
        snap();
        build(LMAC, LPORT + 16'd1, 16'd48, 64'd3, 1'b0, 0); run(0, 1'b0);
        check("wrong_port_drop", 64'(obs_drop - s_drop), 64'd1);

        // Error and truncation
        snap();
        frame_err = 1'b1;
        build(LMAC, LPORT, 16'd48, 64'd4, 1'b0, 0); run(0, 1'b0);
        frame_err = 1'b0;
        check("rx_err_drop", 64'(obs_drop - s_drop), 64'd1);
        snap();
        build(LMAC, LPORT, 16'd200, 64'd5, 1'b0, 0);
        fb = fb[0:60];
        run(0, 1'b0);
        check("trunc60_writes", 64'(obs_wr - s_wr), 64'd2);
        check("trunc60_drop", 64'(obs_drop - s_drop), 64'd1);
        snap();
        build(LMAC, LPORT, 16'd17, 64'd6, 1'b0, 0); run(0, 1'b0);
        check("len17_writes", 64'(obs_wr - s_wr), 64'd0);
        check("len17_drop", 64'(obs_drop - s_drop), 64'd1);

        // Overflow on 10 word boundaries
        snap();
        build(LMAC, LPORT, 16'h05C8, 64'd7, 1'b1, 0);
        cnt = 0;
        while (cnt < 10) begin
            idx = $urandom_range(0, 365);
            if (!full_w[idx]) begin
                full_w[idx] = 1'b1;
                cnt++;
            end
        end
        run(0, 1'b0);
        check("ovf_count_10", 64'(ovf_count), 64'd10);
        check("ovf_writes", 64'(obs_wr - s_wr), 64'd356);
        check("ovf_ok", 64'(obs_ok - s_ok), 64'd1);

        // SOP mid-frame abort
        snap();
        build(LMAC, LPORT, 16'd200, 64'd8, 1'b0, 0);
        fb = fb[0:99];
        model_frame(1);
        send(1, 1'b1);
        build(LMAC, LPORT, 16'd200, 64'd9, 1'b0, 0);
        run(0, 1'b0);
        check("abort_drop", 64'(obs_drop - s_drop), 64'd1);
        check("abort_next_ok", 64'(obs_ok - s_ok), 64'd1);

        // Reset at index 200
        build(LMAC, LPORT, 16'd400, 64'd10, 1'b0, 0);
        fb = fb[0:199];
        model_frame(2);
        send(2, 1'b0);
        do_reset(1'b1);
        snap();
        build(LMAC, LPORT, 16'd64, 64'd11, 1'b0, 0); run(0, 1'b0);
        check("post_reset_ok", 64'(obs_ok - s_ok), 64'd1);
        check("post_reset_gap", 64'(obs_gap - s_gap), 64'd0);

        // Randomized frames, including back-to-back, aborts and header corruption
        for (int r = 0; r < 40; r++) begin
            gap_pct = $urandom_range(0, 20);
            case ($urandom_range(0, 9))
                0: begin
                    case ($urandom_range(0, 3))
                        0: ulen = 16'd15;
                        1: ulen = 16'd17;
                        2: ulen = 16'd18;
                        default: ulen = 16'd1484;
                    endcase
                end
                1: ulen = 16'd16;
                default: ulen = 16'(16 + 4 * $urandom_range(1, 50));
            endcase
            sq = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : m_last + 64'd1;
            build(($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : LMAC, LPORT, ulen, sq, 1'b0,
                  $urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) begin
                idx = hdr_idx[$urandom_range(0, 10)];
                fb[idx] = fb[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(1, fb.size());
                fb = fb[0:idx-1];
            end
            frame_err = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 64; k++) full_w[k] = ($urandom_range(0, 9) == 0);
            b2b = ($urandom_range(0, 3) == 0);
            term = 0;
            if (r != 39 && $urandom_range(0, 9) == 0) begin
                term = 1;
                b2b = 1'b1;
            end
            if (r == 39) b2b = 1'b0;
            run(term, b2b);
        end
        frame_err = 1'b0;
        end_frame();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
